// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - request/result bundle between the EX stage and the divider
// Signals:
//   signed_div_i  1 = DIV (two's complement), 0 = DIVU
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held by EX until ready_o is seen
//   annul_i       cancel an in-flight divide
//   result_o      {remainder, quotient}
//   ready_o       result_o valid
// Modports: master = EX stage side, slave = divider side.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for DIV/DIVU
// Ports:
//   clk      system clock, all state updates on the rising edge
//   rst      synchronous active-high reset
//   div_bus  div_unit_if.slave: operands, start/annul request, registered
//            {remainder, quotient} result and ready flag
// One quotient bit is produced per clock on operand magnitudes; the signs
// are reapplied in the final cycle before the result is loaded.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  div_bus
);

    typedef enum logic [1:0] {
        S_FREE,
        S_BYZERO,
        S_ON,
        S_END
    } state_t;

    localparam logic [WIDTH-1:0] ZERO    = '0;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [WIDTH-1:0]     rem, rem_n;        // running partial remainder
    logic [WIDTH-1:0]     quo, quo_n;        // dividend bits out, quotient bits in
    logic [WIDTH-1:0]     dsr, dsr_n;        // divisor magnitude
    logic                 neg_q, neg_q_n;
    logic                 neg_r, neg_r_n;
    logic [2*WIDTH-1:0]   result, result_n;
    logic                 ready, ready_n;

    logic                 op1_neg, op2_neg;
    logic [WIDTH-1:0]     abs1, abs2;
    logic [WIDTH:0]       shifted, diff;

    // Negating 0x80000000 yields 0x80000000, read as unsigned 2^31.
    assign op1_neg = div_bus.signed_div_i & div_bus.opdata1_i[WIDTH-1];
    assign op2_neg = div_bus.signed_div_i & div_bus.opdata2_i[WIDTH-1];
    assign abs1    = op1_neg ? ZERO - div_bus.opdata1_i : div_bus.opdata1_i;
    assign abs2    = op2_neg ? ZERO - div_bus.opdata2_i : div_bus.opdata2_i;

    // The remainder stays below the divisor, so WIDTH+1 bits suffice and
    // the top bit of the difference is a clean "borrow, restore" flag.
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, dsr};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_FREE;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dsr    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
            ready  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            rem    <= rem_n;
            quo    <= quo_n;
            dsr    <= dsr_n;
            neg_q  <= neg_q_n;
            neg_r  <= neg_r_n;
            result <= result_n;
            ready  <= ready_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rem_n    = rem;
        quo_n    = quo;
        dsr_n    = dsr;
        neg_q_n  = neg_q;
        neg_r_n  = neg_r;
        result_n = result;
        ready_n  = ready;

        case (state)
            S_FREE: begin
                result_n = '0;
                ready_n  = 1'b0;
                if (div_bus.start_i && !div_bus.annul_i) begin
                    state_n = (div_bus.opdata2_i == ZERO) ? S_BYZERO : S_ON;
                    cnt_n   = '0;
                    rem_n   = '0;
                    quo_n   = abs1;
                    dsr_n   = abs2;
                    neg_q_n = op1_neg ^ op2_neg;
                    neg_r_n = op1_neg;
                end
            end
            S_BYZERO: begin
                state_n  = S_END;
                result_n = '0;
                ready_n  = 1'b1;
            end
            S_ON: begin
                if (div_bus.annul_i) begin
                    state_n  = S_FREE;
                    result_n = '0;
                    ready_n  = 1'b0;
                end else if (cnt != CNT_MAX) begin
                    rem_n = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                    quo_n = {quo[WIDTH-2:0], ~diff[WIDTH]};
                    cnt_n = cnt + CNT_ONE;
                end else begin
                    state_n  = S_END;
                    result_n = {neg_r ? ZERO - rem : rem,
                                neg_q ? ZERO - quo : quo};
                    ready_n  = 1'b1;
                end
            end
            S_END: begin
                if (!div_bus.start_i) begin
                    state_n  = S_FREE;
                    result_n = '0;
                    ready_n  = 1'b0;
                end
            end
            default: begin
                state_n  = S_FREE;
                result_n = '0;
                ready_n  = 1'b0;
            end
        endcase
    end

    assign div_bus.result_o = result;
    assign div_bus.ready_o  = ready;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
module tb_div_unit;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    div_unit_if #(.WIDTH(WIDTH)) bus ();

    div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .div_bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: plain integer division, truncating toward zero.
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 0) return 64'd0;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Timeline model: an accepted request produces its result a fixed
    // number of edges later, held until start drops; annul cancels a
    // real divide but not a divide-by-zero.
    bit          model_on = 0;
    bit          busy = 0, byzero = 0, done = 0;
    int          left = 0;
    logic [63:0] pending = '0;
    logic        exp_ready = 1'b0;
    logic [63:0] exp_res = '0;

    always @(posedge clk) begin
        if (rst) begin
            model_on = 1;
            busy = 0; done = 0; exp_ready = 1'b0; exp_res = '0;
        end else if (done) begin
            if (!bus.start_i) begin
                done = 0; exp_ready = 1'b0; exp_res = '0;
            end
        end else if (busy) begin
            if (bus.annul_i && !byzero) begin
                busy = 0;
            end else begin
                left--;
                if (left == 0) begin
                    busy = 0; done = 1; exp_ready = 1'b1; exp_res = pending;
                end
            end
        end else if (bus.start_i && !bus.annul_i) begin
            busy    = 1;
            byzero  = (bus.opdata2_i == 0);
            left    = byzero ? 1 : WIDTH + 1;
            pending = ref_div(bus.signed_div_i, bus.opdata1_i, bus.opdata2_i);
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk(bus.ready_o === exp_ready, "cmp_ready", 64'(bus.ready_o), 64'(exp_ready));
            chk(bus.result_o === exp_res, "cmp_result", bus.result_o, exp_res);
        end
    end

    // Runs one request; E0 is the first edge with start high.
    task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int exp_edge,
                           input int hold, input string name);
        int n;
        bit got;
        @(negedge clk);
        bus.signed_div_i = s;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        bus.annul_i      = 1'b0;
        n = 0;
        got = 0;
        while (n < 100 && !got) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) begin
                bus.opdata1_i = ~a;
                bus.opdata2_i = $urandom;
            end
            got = bus.ready_o;
        end
        chk(got, {name, "_ready_seen"}, 64'(got), 64'd1);
        chk(n - 1 == exp_edge, {name, "_latency"}, 64'(n - 1), 64'(exp_edge));
        chk(bus.result_o === exp, {name, "_result"}, bus.result_o, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk(bus.ready_o === 1'b1 && bus.result_o === exp, {name, "_hold"},
                bus.result_o, exp);
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        chk(bus.ready_o === 1'b0 && bus.result_o === 64'd0, {name, "_release"},
            {bus.result_o[62:0], bus.ready_o}, 64'd0);
    endtask

    initial begin
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk(bus.ready_o === 1'b0, "reset_ready", 64'(bus.ready_o), 64'd0);
        chk(bus.result_o === 64'd0, "reset_result", bus.result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0, "divu_100_7");
        run_div(1'b1, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0, "div_m7_2");
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33, 0, "div_7_m2");
        run_div(1'b0, 32'd5, 32'd0, 64'd0, 1, 0, "divu_by_zero");
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33, 0, "div_min_m1");
        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, 33, 0, "divu_big");
        run_div(1'b1, 32'd0, 32'd5, 64'd0, 33, 0, "div_zero_dividend");

        // Annul sampled at E10 cancels the divide.
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'hFFFF_FFFF;
        bus.opdata2_i    = 32'd1;
        bus.start_i      = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        chk(bus.ready_o === 1'b0, "annul_no_ready", 64'(bus.ready_o), 64'd0);
        @(negedge clk);
        bus.annul_i = 1'b0;
        @(posedge clk);
        #1;
        chk(bus.ready_o === 1'b0 && bus.result_o === 64'd0, "annul_free",
            bus.result_o, 64'd0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33, 0, "after_annul");

        // Result held while start stays high past ready.
        run_div(1'b0, 32'd1000, 32'd33, {32'd10, 32'd30}, 33, 5, "hold_1000_33");

        // Reset sampled at E20 of a divide.
        @(negedge clk);
        bus.signed_div_i = 1'b1;
        bus.opdata1_i    = 32'hFFFF_FF9C;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        chk(bus.ready_o === 1'b0 && bus.result_o === 64'd0, "mid_reset",
            {bus.result_o[62:0], bus.ready_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33, 0, "after_reset");

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
